fifo_wptr_full: RTL

//  Write-side pointer and full-flag generator for the dual-clock async FIFO, all in the wclk domain.

---
 rtl/fifo_wptr_full_pkg.sv | 27 ++
 rtl/fifo_wptr_full_sync_r2w.sv | 36 +++
 rtl/fifo_wptr_full.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_wptr_full_pkg.sv
// Shared definitions for the async FIFO pointer blocks (write and read side).
// Contents:
//   FIFO_ASIZE_DEFAULT : default address width (depth = 2**ASIZE)
//   bin2gray/gray2bin  : pointer code conversions on a 32-bit word; callers
//                        zero-extend their pointer in and size-cast the result back.
package fifo_wptr_full_pkg;

  localparam int FIFO_ASIZE_DEFAULT = 4;

  typedef logic [31:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it; zero
  // extension above the real pointer width leaves the result unchanged.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_sync_r2w.sv
// Two-flop synchronizer bringing the Gray read pointer into the wclk domain.
// Ports:
//   wclk   : write clock
//   wrstn  : asynchronous active-low reset
//   rptr   : Gray read pointer from the read-clock domain
//   w_rptr : rptr after two wclk flops
module sync_r2w #(
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrstn,
  input  logic [ASIZE:0]   rptr,
  output logic [ASIZE:0]   w_rptr
);

  logic [ASIZE:0] r1_rptr_q, r1_rptr_d;
  logic [ASIZE:0] w_rptr_q,  w_rptr_d;

  always_comb begin
    r1_rptr_d = rptr;
    w_rptr_d  = r1_rptr_q;
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      r1_rptr_q <= '0;
      w_rptr_q  <= '0;
    end else begin
      r1_rptr_q <= r1_rptr_d;
      w_rptr_q  <= w_rptr_d;
    end
  end

  assign w_rptr = w_rptr_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full flag, fill level and overflow flag of the dual-clock
// async FIFO. Everything here runs on wclk; rptr is only seen through sync_r2w.
// Ports:
//   wclk, wrstn   : clock, asynchronous active-low reset
//   winc          : write request
//   rptr          : Gray read pointer (read-clock domain)
//   waddr         : RAM write address (low ASIZE bits of the binary pointer)
//   wptr          : registered Gray write pointer, to the read domain
//   wfull         : registered full flag
//   wlevel        : registered pessimistic fill level, 0..2**ASIZE
//   wovf          : sticky overflow (write attempted while full)
//   walmost_full  : registered almost-full flag
// Configuration macro: WPTR_ALMOST_FULL_EN enables walmost_full
// (level >= 2**ASIZE - AF_MARGIN); otherwise walmost_full is constant 0.
import fifo_wptr_full_pkg::*;

module fifo_wptr_full #(
  parameter int ASIZE     = FIFO_ASIZE_DEFAULT,
  parameter int AF_MARGIN = 2
) (
  input  logic             wclk,
  input  logic             wrstn,
  input  logic             winc,
  input  logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic [ASIZE:0]   wlevel,
  output logic             wovf,
  output logic             walmost_full
);

  localparam int PW = ASIZE + 1;

  if (ASIZE < 2 || AF_MARGIN < 0 || AF_MARGIN > (1 << ASIZE)) begin : g_bad_params
    $error("fifo_wptr_full: ASIZE must be >= 2 and AF_MARGIN within 0..2**ASIZE");
  end

  logic [ASIZE:0] w_rptr;
  logic [ASIZE:0] rbin;
  logic           wacc;

  logic [ASIZE:0] wbin_q,   wbin_d;
  logic [ASIZE:0] wptr_q,   wptr_d;
  logic [ASIZE:0] wlevel_q, wlevel_d;
  logic           wfull_q,  wfull_d;
  logic           wovf_q,   wovf_d;
  logic           waf_q,    waf_d;

  sync_r2w #(.ASIZE(ASIZE)) u_sync_r2w (
    .wclk   (wclk),
    .wrstn  (wrstn),
    .rptr   (rptr),
    .w_rptr (w_rptr)
  );

`ifdef WPTR_ALMOST_FULL_EN
  localparam logic [ASIZE:0] AF_THRESH = PW'((1 << ASIZE) - AF_MARGIN);
`endif

  always_comb begin
    wacc     = winc & ~wfull_q;
    wbin_d   = wbin_q + {{ASIZE{1'b0}}, wacc};
    wptr_d   = PW'(bin2gray(32'(wbin_d)));
    rbin     = PW'(gray2bin(32'(w_rptr)));
    wlevel_d = wbin_d - rbin;
    // Full when the pointers differ only in the wrap bit: in Gray code that
    // is the top two bits inverted, the rest equal.
    wfull_d  = (wptr_d == {~w_rptr[ASIZE:ASIZE-1], w_rptr[ASIZE-2:0]});
    wovf_d   = wovf_q | (winc & wfull_q);
`ifdef WPTR_ALMOST_FULL_EN
    waf_d    = (wlevel_d >= AF_THRESH);
`else
    waf_d    = 1'b0;
`endif
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wovf_q   <= 1'b0;
      waf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wovf_q   <= wovf_d;
      waf_q    <= waf_d;
    end
  end

  assign waddr        = wbin_q[ASIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;
  assign walmost_full = waf_q;

endmodule
